// File: rtl/vdp_super_res_writer.sv
// CPU byte-write path into super-res VRAM: queues bytes at an auto-incrementing
// address and issues 32-bit word writes with one-hot byte enables outside the display window.
module vdp_super_res_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdp_super,
    input  logic              super_res_drawing,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              data_wr,
    input  logic [7:0]        data_in,
    output logic              vram_wr_req,
    output logic [ADDR_W-3:0] vram_wr_addr,
    output logic [31:0]       vram_wr_data,
    output logic [3:0]        vram_wr_be,
    input  logic              vram_wr_ack,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]    wr_idx_q, rd_idx_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                req_q, req_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          be_q, be_d;
    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

    logic [ADDR_W-1:0]   push_addr;
    logic [ADDR_W-1:0]   head_addr;
    logic [7:0]          head_data;
    logic                full_c;
    logic                pop;
    logic                push;
    logic                drop;

    // The in-flight word keeps its slot until acked, so an ack frees space the same cycle.
    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = (state_q == ISSUE) && vram_wr_ack;
    assign push      = data_wr && (!full_c || pop);
    assign drop      = data_wr && full_c && !pop;
    assign push_addr = addr_load ? addr_in : ptr_q;
    assign head_addr = mem_q[rd_idx_q][ENTRY_W-1:8];
    assign head_data = mem_q[rd_idx_q][7:0];

    always_comb begin
        ptr_d      = ptr_q;
        overflow_d = overflow_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (data_wr) begin
            ptr_d = push_addr + ADDR_W'(1);
        end else if (addr_load) begin
            ptr_d = addr_in;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (addr_load) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !super_res_drawing) begin
                    state_d = ISSUE;
                    req_d   = 1'b1;
                    addr_d  = head_addr[ADDR_W-1:2];
                    data_d  = {4{head_data}};
                    be_d    = 4'b0001 << head_addr[1:0];
                end
            end
            ISSUE: begin
                // Request stays up with stable payload until acked, whatever the display does.
                if (vram_wr_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
        end else if (!vdp_super) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            if (push) begin
                wr_idx_q <= wr_idx_q + PTR_W'(1);
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the indices and count.
    always_ff @(posedge clk) begin
        if (push && vdp_super) begin
            mem_q[wr_idx_q] <= {push_addr, data_in};
        end
    end

    assign vram_wr_req  = req_q;
    assign vram_wr_addr = addr_q;
    assign vram_wr_data = data_q;
    assign vram_wr_be   = be_q;
    assign fifo_full    = full_c;
    assign fifo_empty   = (count_q == '0);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Directed bench for vdp_super_res_writer: hand-computed expectations checked with immediate assertions.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vdp_super;
    logic        super_res_drawing;
    logic        addr_load;
    logic [18:0] addr_in;
    logic        data_wr;
    logic [7:0]  data_in;
    logic        vram_wr_req;
    logic [16:0] vram_wr_addr;
    logic [31:0] vram_wr_data;
    logic [3:0]  vram_wr_be;
    logic        vram_wr_ack;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    vdp_super_res_writer dut (
        .clk               (clk),
        .reset             (reset),
        .vdp_super         (vdp_super),
        .super_res_drawing (super_res_drawing),
        .addr_load         (addr_load),
        .addr_in           (addr_in),
        .data_wr           (data_wr),
        .data_in           (data_in),
        .vram_wr_req       (vram_wr_req),
        .vram_wr_addr      (vram_wr_addr),
        .vram_wr_data      (vram_wr_data),
        .vram_wr_be        (vram_wr_be),
        .vram_wr_ack       (vram_wr_ack),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        data_wr = 1'b1;
        data_in = b;
        tick();
        data_wr = 1'b0;
    endtask

    task automatic load(input logic [18:0] a);
        addr_load = 1'b1;
        addr_in   = a;
        tick();
        addr_load = 1'b0;
    endtask

    task automatic ack();
        vram_wr_ack = 1'b1;
        tick();
        vram_wr_ack = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic [18:0] a, input logic [7:0] b);
        chk({tag, "_req"}, 32'(vram_wr_req), 32'd1);
        chk({tag, "_addr"}, 32'(vram_wr_addr), 32'(a >> 2));
        chk({tag, "_be"}, 32'(vram_wr_be), 32'(4'b0001 << a[1:0]));
        chk({tag, "_data"}, vram_wr_data, {4{b}});
    endtask

    initial begin
        reset = 1'b1; vdp_super = 1'b1; super_res_drawing = 1'b0;
        addr_load = 1'b0; addr_in = '0; data_wr = 1'b0; data_in = '0; vram_wr_ack = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(vram_wr_req), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(vram_wr_addr), 32'd0);
        chk("rst_be", 32'(vram_wr_be), 32'd0);
        chk("rst_data", vram_wr_data, 32'd0);
        reset = 1'b0;
        tick();

        // 1: basic write, two-edge latency, pointer auto-increment
        load(19'h00005);
        wr(8'hAB);
        chk("t1_noreq_yet", 32'(vram_wr_req), 32'd0);
        chk("t1_notempty", 32'(fifo_empty), 32'd0);
        tick();
        chk_req("t1", 19'h00005, 8'hAB);
        ack();
        chk("t1_req_drop", 32'(vram_wr_req), 32'd0);
        chk("t1_empty", 32'(fifo_empty), 32'd1);
        wr(8'hCD);
        tick();
        chk_req("t1_next", 19'h00006, 8'hCD);
        ack();
        // Ack while idle must not disturb anything
        ack();
        chk("idle_ack_req", 32'(vram_wr_req), 32'd0);
        chk("idle_ack_empty", 32'(fifo_empty), 32'd1);

        // 2: pointer wrap
        load(19'h7FFFF);
        wr(8'h11);
        wr(8'h22);
        chk_req("t2_a", 19'h7FFFF, 8'h11);
        ack();
        chk("t2_gap", 32'(vram_wr_req), 32'd0);
        tick();
        chk_req("t2_b", 19'h00000, 8'h22);
        ack();

        // 3: window closed, fill, overflow, ordered drain
        super_res_drawing = 1'b1;
        load(19'h00100);
        for (int i = 0; i < 4; i++) wr(8'(i + 1));
        chk("t3_noreq", 32'(vram_wr_req), 32'd0);
        chk("t3_full", 32'(fifo_full), 32'd1);
        wr(8'h05);
        chk("t3_ovf", 32'(overflow), 32'd1);
        super_res_drawing = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_req("t3_drain", 19'(19'h00100 + i), 8'(i + 1));
            ack();
        end
        chk("t3_empty", 32'(fifo_empty), 32'd1);
        chk("t3_ovf_held", 32'(overflow), 32'd1);
        load(19'h00000);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // 4: outstanding request held through display window and delayed ack
        addr_load = 1'b1; addr_in = 19'h00208;
        wr(8'h5A);
        addr_load = 1'b0;
        tick();
        chk_req("t4_start", 19'h00208, 8'h5A);
        super_res_drawing = 1'b1;
        wr(8'h6B);
        for (int i = 0; i < 9; i++) begin
            chk_req("t4_hold", 19'h00208, 8'h5A);
            tick();
        end
        ack();
        for (int i = 0; i < 3; i++) begin
            chk("t4_blocked", 32'(vram_wr_req), 32'd0);
            tick();
        end
        super_res_drawing = 1'b0;
        tick();
        chk_req("t4_resume", 19'h00209, 8'h6B);
        ack();

        // 5: full FIFO, ack and data_wr in the same cycle
        load(19'h00300);
        for (int i = 0; i < 4; i++) wr(8'(8'h71 + i));
        chk("t5_full", 32'(fifo_full), 32'd1);
        chk_req("t5_first", 19'h00300, 8'h71);
        vram_wr_ack = 1'b1;
        wr(8'h75);
        vram_wr_ack = 1'b0;
        chk("t5_ovf", 32'(overflow), 32'd0);
        chk("t5_still_full", 32'(fifo_full), 32'd1);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_req("t5_drain", 19'(19'h00300 + i), 8'(8'h71 + i));
            ack();
        end
        chk("t5_empty", 32'(fifo_empty), 32'd1);

        // 6a: async reset during ISSUE with three queued
        load(19'h00400);
        for (int i = 0; i < 4; i++) wr(8'(8'h90 + i));
        chk("t6a_req_before", 32'(vram_wr_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6a_req_async", 32'(vram_wr_req), 32'd0);
        chk("t6a_empty", 32'(fifo_empty), 32'd1);
        chk("t6a_full", 32'(fifo_full), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6a_quiet", 32'(vram_wr_req), 32'd0);
        end

        // 6b: vdp_super low during ISSUE flushes everything, pointer included
        load(19'h00500);
        for (int i = 0; i < 4; i++) wr(8'(8'hA0 + i));
        chk("t6b_req_before", 32'(vram_wr_req), 32'd1);
        vdp_super = 1'b0;
        tick();
        chk("t6b_req", 32'(vram_wr_req), 32'd0);
        chk("t6b_empty", 32'(fifo_empty), 32'd1);
        chk("t6b_be", 32'(vram_wr_be), 32'd0);
        vdp_super = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6b_quiet", 32'(vram_wr_req), 32'd0);
        end
        wr(8'hEE);
        tick();
        chk_req("t6b_ptr0", 19'h00000, 8'hEE);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
